rr_grant_index_gen: RTL and testbench
=====================================

// Module: rr_grant_index_gen
// PURPOSE
//  Round-robin arbiter for 16 requesters; upstream stage of the 4-to-16 one-hot decoder.
//  Emits a registered binary grant index plus valid.
//  grant_idx drives the decoder select and grant_vld drives its enable; together they form a one-hot grant bus.
//  Each grant is held until the owner releases it.
// PARAMETERS
//  N_REQ     16   number of requesters (fixed at 16 to match the decoder)
//  IDX_W     4    grant index width, $clog2(N_REQ)
//  MAX_HOLD  64   max cycles in GRANT before forced release (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  arb_en     in   1      1 = new grants may be issued; 0 = no new grants (current grant continues)
//  req        in   16     request vector, level-sensitive, bit i = requester i
//  rel        in   1      one-cycle release pulse from the current owner
//  grant_idx  out  4      index of the current owner (to decoder select)
//  grant_vld  out  1      grant active (to decoder enable)
//  rr_ptr     out  4      highest-priority index for the next arbitration
//  timeout    out  1      one-cycle pulse on forced release
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, grant_idx=0, grant_vld=0, rr_ptr=0, timeout=0, hold_cnt=0.
//  Reset mid-grant aborts the grant at once; no release is reported.
//  States (arb_state_t): IDLE, GRANT, GAP.
//  IDLE:
//   - If arb_en=1 and |req, pick the first set bit scanning rr_ptr, rr_ptr+1, .., 15, 0, .., rr_ptr-1.
//   - Next cycle: grant_idx=winner, grant_vld=1, state=GRANT. Latency: 1 clk from req sampled to grant_vld.
//   - Otherwise stay in IDLE with grant_vld=0.
//  GRANT:
//   - grant_idx and grant_vld are held stable; req changes on other bits are ignored.
//   - End of grant, on any of:
//     rel=1; req[grant_idx]=0 (owner withdrew, treated as release); timeout (see CONFIGURATION).
//   - At end of grant, next cycle: grant_vld=0, rr_ptr=grant_idx+1 mod 16 (15 wraps to 0), state=GAP.
//   - rel while in IDLE/GAP is ignored.
//  GAP: exactly one cycle with grant_vld=0 (bus turnaround), then IDLE.
//   - Consequence: the minimum spacing between two grants is 2 idle cycles of grant_vld.
//  arb_en=0 blocks only the IDLE->GRANT transition; an active grant completes normally.
//  Simultaneous rel and timeout in the same cycle: treated as a release; timeout stays 0.
//  A single requester that is re-granted continuously is allowed; rr_ptr still advances past it.
//  grant_idx retains its last value while grant_vld=0; consumers must qualify it with grant_vld.
// CONFIGURATION
//  Macro ARB_TIMEOUT_EN.
//  Defined:
//   - hold_cnt [$clog2(MAX_HOLD+1)-1:0] clears on entry to GRANT and increments each GRANT cycle.
//   - When hold_cnt==MAX_HOLD-1 with no rel, force release: timeout=1 for one cycle, coincident with
//     the grant_vld 1->0 edge; rr_ptr advances as for a normal release.
//  Not defined:
//   - No counter is built; timeout is tied to 0; a grant lasts until rel or withdrawal.
// STRUCTURE
//  Package arb_pkg:
//   - arb_state_t enum {IDLE, GRANT, GAP}
//   - localparams N_REQ=16, IDX_W=4
//   - function rr_pick(req, ptr) returning {found, idx}
//  Sub-module rr_priority_pick: combinational masked priority encoder.
//   - Inputs: req[15:0], ptr[3:0]. Outputs: found, idx[3:0].
//   - Method: mask bits below ptr and pick the lowest set bit; if none, pick the lowest set bit of
//     the unmasked req.
//  Top level: FSM, registered outputs, optional hold counter.
// TESTING
//  1. Assert rst mid-GRANT (grant_idx=5) -> grant_vld=0, rr_ptr=0 without waiting for clk.
//  2. req=16'h0001, rr_ptr=0, arb_en=1 -> grant_idx=0, grant_vld=1 one clk later.
//     Then rel -> grant_vld=0, rr_ptr=1, 1 GAP cycle, re-grant idx 0.
//  3. req=16'h8421 held, each grant released after 3 clks -> grant order 0,5,10,15,0; ptr wraps 15->0.
//  4. Granted idx 3, drop req[3] with no rel -> grant_vld=0 next clk, rr_ptr=4, timeout=0.
//  5. arb_en=0 with req=16'hFFFF -> grant_vld stays 0.
//     arb_en=0 during an active grant -> grant held until rel.
//  6. ARB_TIMEOUT_EN, MAX_HOLD=8: hold grant idx 7 with no rel -> timeout pulse after 8 GRANT clks,
//     rr_ptr=8. Without the macro, the same stimulus holds the grant indefinitely.

Source files
------------

// File: rtl/rr_grant_index_gen_pkg.sv
// arb_pkg: shared types and helpers for the rr_grant_index_gen arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, GAP)
//   N_REQ/IDX_W : requester count and grant index width (fixed at 16 / 4)
//   pick_t      : {found, idx} result of a round-robin pick
//   rr_pick()   : masked priority pick starting at ptr, wrapping to 0
package arb_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Masking bits below ptr and taking the lowest set bit gives the scan
    // order ptr..15; falling back to the unmasked vector covers 0..ptr-1.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [IDX_W-1:0] ptr);
        logic [N_REQ-1:0] mask;
        logic [N_REQ-1:0] src;
        logic             hit;
        pick_t            res;
        mask      = {N_REQ{1'b1}} << ptr;
        src       = (|(req & mask)) ? (req & mask) : req;
        hit       = 1'b0;
        res.found = |req;
        res.idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (src[i] && !hit) begin
                hit     = 1'b1;
                res.idx = IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_grant_index_gen_if.sv
// Arbiter bus: request side (arb_en, req, rel) and grant side
// (grant_idx, grant_vld, rr_ptr, timeout).
//   master : requester/environment side, drives requests
//   slave  : arbiter side, drives grant outputs
interface rr_grant_index_gen_if;
    import arb_pkg::*;

    logic             arb_en;
    logic [N_REQ-1:0] req;
    logic             rel;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;
    logic [IDX_W-1:0] rr_ptr;
    logic             timeout;

    modport master (
        output arb_en, req, rel,
        input  grant_idx, grant_vld, rr_ptr, timeout
    );

    modport slave (
        input  arb_en, req, rel,
        output grant_idx, grant_vld, rr_ptr, timeout
    );

endinterface

// File: rtl/rr_grant_index_gen_pick.sv
// rr_priority_pick: combinational round-robin priority encoder.
//   req_i   : request vector
//   ptr_i   : highest-priority index
//   found_o : at least one request set
//   idx_o   : first set index scanning ptr_i upward with wrap
module rr_priority_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    pick_t pick;

    always_comb begin
        pick    = rr_pick(req_i, ptr_i);
        found_o = pick.found;
        idx_o   = pick.idx;
    end

endmodule

// File: rtl/rr_grant_index_gen.sv
// rr_grant_index_gen: 16-way round-robin arbiter producing a registered
// binary grant index + valid for a downstream 4-to-16 one-hot decoder.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : rr_grant_index_gen_if.slave (arb_en, req, rel in;
//          grant_idx, grant_vld, rr_ptr, timeout out)
// Optional macro ARB_TIMEOUT_EN adds a hold counter that forces release
// after MAX_HOLD GRANT cycles; otherwise timeout is tied low.
module rr_grant_index_gen
    import arb_pkg::*;
#(
`ifdef ARB_TIMEOUT_EN
    parameter int unsigned MAX_HOLD = 64
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_grant_index_gen_if.slave  bus
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             grant_vld_q, grant_vld_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             release_req;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              timeout_q, timeout_d;
`endif

    rr_priority_pick u_pick (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            grant_vld_q <= 1'b0;
            rr_ptr_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            grant_vld_q <= grant_vld_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        grant_vld_d = grant_vld_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
`endif
        // Owner withdrawing its request counts the same as an explicit release.
        release_req = bus.rel || !bus.req[grant_idx_q];

        case (state_q)
            IDLE: begin
                grant_vld_d = 1'b0;
                if (bus.arb_en && pick_found) begin
                    grant_idx_d = pick_idx;
                    grant_vld_d = 1'b1;
                    state_d     = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (release_req) begin
                    grant_vld_d = 1'b0;
                    rr_ptr_d    = grant_idx_q + IDX_W'(1);
                    state_d     = GAP;
                end
`ifdef ARB_TIMEOUT_EN
                // Release wins over a coincident expiry, so timeout only
                // fires when nothing else ended the grant.
                else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
                    grant_vld_d = 1'b0;
                    rr_ptr_d    = grant_idx_q + IDX_W'(1);
                    state_d     = GAP;
                    timeout_d   = 1'b1;
                end else begin
                    hold_cnt_d  = hold_cnt_q + HOLD_W'(1);
                end
`endif
            end
            GAP: begin
                grant_vld_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                grant_vld_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign bus.grant_idx = grant_idx_q;
    assign bus.grant_vld = grant_vld_q;
    assign bus.rr_ptr    = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_index_gen.sv
// Directed testbench for rr_grant_index_gen. Inputs change 1 time unit after
// the rising edge; outputs are checked at the same point.
module tb_rr_grant_index_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks   = 0;
    int unsigned failures = 0;

    rr_grant_index_gen_if bus ();

    always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
    rr_grant_index_gen #(.MAX_HOLD(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    rr_grant_index_gen dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned order[5];
        order[0] = 0; order[1] = 5; order[2] = 10; order[3] = 15; order[4] = 0;

        bus.arb_en = 1'b0;
        bus.req    = '0;
        bus.rel    = 1'b0;
        rst        = 1'b1;
        tick();
        tick();
        chk("rst_vld", 32'(bus.grant_vld), 32'd0);
        chk("rst_idx", 32'(bus.grant_idx), 32'd0);
        chk("rst_ptr", 32'(bus.rr_ptr), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        rst = 1'b0;

        // Single requester 0: grant, release, gap, re-grant.
        bus.req = 16'h0001;
        bus.arb_en = 1'b1;
        tick();
        chk("t2_vld", 32'(bus.grant_vld), 32'd1);
        chk("t2_idx", 32'(bus.grant_idx), 32'd0);
        bus.rel = 1'b1;
        tick();
        bus.rel = 1'b0;
        chk("t2_rel_vld", 32'(bus.grant_vld), 32'd0);
        chk("t2_rel_ptr", 32'(bus.rr_ptr), 32'd1);
        tick();
        chk("t2_idle_vld", 32'(bus.grant_vld), 32'd0);
        tick();
        chk("t2_regrant_vld", 32'(bus.grant_vld), 32'd1);
        chk("t2_regrant_idx", 32'(bus.grant_idx), 32'd0);
        bus.rel = 1'b1;
        tick();
        bus.rel = 1'b0;
        bus.req = '0;
        chk("t2_rel2_ptr", 32'(bus.rr_ptr), 32'd1);
        tick();

        // Owner 3 withdraws its request without rel.
        bus.req = 16'h0008;
        tick();
        chk("t4_idx", 32'(bus.grant_idx), 32'd3);
        chk("t4_vld", 32'(bus.grant_vld), 32'd1);
        bus.req = '0;
        tick();
        chk("t4_wd_vld", 32'(bus.grant_vld), 32'd0);
        chk("t4_wd_ptr", 32'(bus.rr_ptr), 32'd4);
        chk("t4_wd_timeout", 32'(bus.timeout), 32'd0);
        tick();

        // arb_en=0 blocks new grants but not an active one.
        bus.arb_en = 1'b0;
        bus.req = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_blocked_vld", 32'(bus.grant_vld), 32'd0);
        end
        bus.arb_en = 1'b1;
        tick();
        chk("t5_grant_idx", 32'(bus.grant_idx), 32'd4);
        bus.arb_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_vld", 32'(bus.grant_vld), 32'd1);
            chk("t5_hold_idx", 32'(bus.grant_idx), 32'd4);
        end
        bus.rel = 1'b1;
        tick();
        bus.rel = 1'b0;
        bus.req = '0;
        bus.arb_en = 1'b1;
        chk("t5_rel_vld", 32'(bus.grant_vld), 32'd0);
        chk("t5_rel_ptr", 32'(bus.rr_ptr), 32'd5);
        tick();

        // Asynchronous reset in the middle of a grant to requester 5.
        bus.req = 16'h0020;
        tick();
        chk("t1_pre_idx", 32'(bus.grant_idx), 32'd5);
        chk("t1_pre_vld", 32'(bus.grant_vld), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_async_vld", 32'(bus.grant_vld), 32'd0);
        chk("t1_async_ptr", 32'(bus.rr_ptr), 32'd0);
        chk("t1_async_idx", 32'(bus.grant_idx), 32'd0);
        bus.req = '0;
        tick();
        rst = 1'b0;

        // Rotation over 0,5,10,15 with pointer wrap.
        bus.req = 16'h8421;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_vld", 32'(bus.grant_vld), 32'd1);
            chk("t3_idx", 32'(bus.grant_idx), 32'(order[k]));
            tick();
            tick();
            chk("t3_held_idx", 32'(bus.grant_idx), 32'(order[k]));
            bus.rel = 1'b1;
            tick();
            bus.rel = 1'b0;
            chk("t3_rel_vld", 32'(bus.grant_vld), 32'd0);
            chk("t3_rel_ptr", 32'(bus.rr_ptr), 32'((order[k] + 1) % 16));
            tick();
        end
        bus.req = '0;

        // Held grant to requester 7 with no release.
        bus.req = 16'h0080;
        tick();
        chk("t6_idx", 32'(bus.grant_idx), 32'd7);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t6_hold_vld", 32'(bus.grant_vld), 32'd1);
            chk("t6_hold_timeout", 32'(bus.timeout), 32'd0);
        end
        tick();
        bus.req = '0;
        chk("t6_to_vld", 32'(bus.grant_vld), 32'd0);
        chk("t6_to_pulse", 32'(bus.timeout), 32'd1);
        chk("t6_to_ptr", 32'(bus.rr_ptr), 32'd8);
        tick();
        chk("t6_to_end", 32'(bus.timeout), 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t6_hold_vld", 32'(bus.grant_vld), 32'd1);
            chk("t6_hold_timeout", 32'(bus.timeout), 32'd0);
        end
        bus.rel = 1'b1;
        tick();
        bus.rel = 1'b0;
        bus.req = '0;
        chk("t6_rel_vld", 32'(bus.grant_vld), 32'd0);
        chk("t6_rel_ptr", 32'(bus.rr_ptr), 32'd8);
        chk("t6_rel_timeout", 32'(bus.timeout), 32'd0);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
